// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared grid geometry, FSM states and display colours for the life updater
package life_pkg;

   localparam int ROWS = 15;
   localparam int COLS = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_PWAIT,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } life_state_e;

   // 12-bit RGB used by the display path when rendering sprites
   localparam logic [11:0] COLOUR_ALIVE = 12'h0F0;
   localparam logic [11:0] COLOUR_DEAD  = 12'h000;
   localparam logic [11:0] COLOUR_GRID  = 12'h333;

endpackage

// File: rtl/life_row_calc.sv
// rtl/life_row_calc.sv - next-generation row word from the rows above, at and below
module life_row_calc #(
   parameter int COLS = 20
) (
   input  logic [COLS-1:0] i_prev,
   input  logic [COLS-1:0] i_cur,
   input  logic [COLS-1:0] i_next,
   output logic [COLS-1:0] o_row
);

   // one dead guard column on each side: bit c+1 of these holds column c
   logic [COLS+1:0] w_p;
   logic [COLS+1:0] w_c;
   logic [COLS+1:0] w_n;
   logic [3:0]      w_cnt;

   assign w_p = {1'b0, i_prev, 1'b0};
   assign w_c = {1'b0, i_cur,  1'b0};
   assign w_n = {1'b0, i_next, 1'b0};

   function automatic logic [3:0] f_b(input logic b);
      return {3'b000, b};
   endfunction

   always_comb begin
      o_row = '0;
      w_cnt = '0;
      for (int c = 0; c < COLS; c++) begin
         w_cnt = f_b(w_p[c]) + f_b(w_p[c+1]) + f_b(w_p[c+2])
               + f_b(w_c[c])                 + f_b(w_c[c+2])
               + f_b(w_n[c]) + f_b(w_n[c+1]) + f_b(w_n[c+2]);
         o_row[c] = (w_cnt == 4'd3) || (w_c[c+1] && (w_cnt == 4'd2));
      end
   end

endmodule

// File: rtl/life_updater.sv
// rtl/life_updater.sv - in-place Game of Life generation step over a row-addressed grid memory
module life_updater #(
   parameter int ROWS = life_pkg::ROWS,
   parameter int COLS = life_pkg::COLS
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   output logic            o_rd_en,
   output logic [3:0]      o_rd_row,
   input  logic [COLS-1:0] i_rd_data,
   output logic            o_wr_en,
   output logic [3:0]      o_wr_row,
   output logic [COLS-1:0] o_wr_data,
   output logic            o_busy,
   output logic            o_done,
   output logic [15:0]     o_gen
);

   import life_pkg::*;

   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

   life_state_e     r_state;
   life_state_e     w_state_nxt;
   logic [3:0]      r_row;
   logic [COLS-1:0] r_prev;
   logic [COLS-1:0] r_cur;
   logic [COLS-1:0] r_next;
   logic [COLS-1:0] w_row_new;
   logic [15:0]     r_gen;
   logic            w_rd_en;
   logic            w_wr_en;
   logic [3:0]      w_rd_row;

   life_row_calc #(.COLS(COLS)) u_row_calc (
      .i_prev (r_prev),
      .i_cur  (r_cur),
      .i_next (r_next),
      .o_row  (w_row_new)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_prev  <= '0;
         r_cur   <= '0;
         r_next  <= '0;
         r_gen   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_PRIME: r_prev <= '0;
            ST_PWAIT: begin
               r_cur <= i_rd_data;
               r_row <= '0;
            end
            // below the last row the grid is dead
            ST_WAIT:  r_next <= (r_row != LAST_ROW) ? i_rd_data : '0;
            ST_WRITE: begin
               r_prev <= r_cur;
               r_cur  <= r_next;
               if (r_row != LAST_ROW) r_row <= r_row + 4'd1;
            end
            ST_DONE:  r_gen <= r_gen + 16'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_rd_row    = '0;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_IDLE:  if (i_start) w_state_nxt = ST_PRIME;
         ST_PRIME: begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_PWAIT;
         end
         ST_PWAIT: w_state_nxt = ST_READ;
         ST_READ: begin
            if (r_row != LAST_ROW) begin
               w_rd_en  = 1'b1;
               w_rd_row = r_row + 4'd1;
            end
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT:  w_state_nxt = ST_WRITE;
         ST_WRITE: begin
            w_wr_en     = 1'b1;
            w_state_nxt = (r_row == LAST_ROW) ? ST_DONE : ST_READ;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // strobes are masked by reset so an abort suppresses the write in flight
   assign o_rd_en   = w_rd_en & i_rst_n;
   assign o_rd_row  = w_rd_row;
   assign o_wr_en   = w_wr_en & i_rst_n;
   assign o_wr_row  = r_row;
   assign o_wr_data = w_row_new;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_done    = (r_state == ST_DONE);
   assign o_gen     = r_gen;

endmodule

// File: tb/tb_life_updater.sv
// tb/tb_life_updater.sv - scoreboard bench for life_updater against a cell-level reference model
module tb_life_updater;

   localparam int ROWS = 15;
   localparam int COLS = 20;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            rd_en;
   logic [3:0]      rd_row;
   logic [COLS-1:0] rd_data;
   logic            wr_en;
   logic [3:0]      wr_row;
   logic [COLS-1:0] wr_data;
   logic            busy;
   logic            done;
   logic [15:0]     gen;

   always #5 clk = ~clk;

   life_updater #(.ROWS(ROWS), .COLS(COLS)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .o_rd_en   (rd_en),
      .o_rd_row  (rd_row),
      .i_rd_data (rd_data),
      .o_wr_en   (wr_en),
      .o_wr_row  (wr_row),
      .o_wr_data (wr_data),
      .o_busy    (busy),
      .o_done    (done),
      .o_gen     (gen)
   );

   logic [COLS-1:0] mem [16];
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_row];
      if (wr_en) mem[wr_row] <= wr_data;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [23:0] exp_q [$];
   logic [23:0] e;
   int          wr_cnt = 0;

   always @(negedge clk) begin
      if (busy) check("rd_wr_exclusive", 32'(rd_en & wr_en), 32'd0);
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(wr_row), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_row", 32'(wr_row), 32'(e[23:20]));
            check("wr_data", 32'(wr_data), 32'(e[19:0]));
         end
      end
   end

   logic [COLS-1:0] model [ROWS];
   logic [COLS-1:0] old_grid [ROWS];
   logic [15:0]     exp_gen = '0;

   task automatic model_step();
      logic [COLS-1:0] nx [ROWS];
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < ROWS &&
                      c + dc >= 0 && c + dc < COLS)
                     n += int'(model[r+dr][c+dc]);
            nx[r][c] = (n == 3) || (model[r][c] && n == 2);
         end
      end
      for (int r = 0; r < ROWS; r++) model[r] = nx[r];
   endtask

   task automatic push_expect(input int nrows);
      for (int r = 0; r < nrows; r++) exp_q.push_back({4'(r), model[r]});
   endtask

   task automatic load_grid();
      for (int r = 0; r < ROWS; r++) mem[r] <= model[r];
      mem[15] <= '0;
      @(negedge clk);
   endtask

   task automatic run_gen(input string tag);
      int first_wr = -1;
      int done_cyc = -1;
      logic busy_ok = 1'b1;
      model_step();
      push_expect(ROWS);
      exp_gen = exp_gen + 16'd1;
      wr_cnt = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
         @(negedge clk);
         if (wr_en && first_wr < 0) first_wr = k;
         if (!busy) busy_ok = 1'b0;
         if (done) done_cyc = k;
      end
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'd48);
      check({tag, "_first_write"}, 32'(first_wr), 32'd5);
      check({tag, "_busy_throughout"}, 32'(busy_ok), 32'd1);
      @(negedge clk);
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_gen"}, 32'(gen), 32'(exp_gen));
      check({tag, "_write_count"}, 32'(wr_cnt), 32'(ROWS));
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int d1, d2, idle_between, hit;
      for (int r = 0; r < ROWS; r++) model[r] = '0;
      load_grid();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_gen", 32'(gen), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // blinker
      for (int r = 0; r < ROWS; r++) model[r] = '0;
      model[7] = 20'h00E00;
      load_grid();
      run_gen("blink1");
      check("blink1_r6", 32'(mem[6]), 32'h00400);
      check("blink1_r7", 32'(mem[7]), 32'h00400);
      check("blink1_r8", 32'(mem[8]), 32'h00400);
      run_gen("blink2");
      check("blink2_r6", 32'(mem[6]), 32'h0);
      check("blink2_r7", 32'(mem[7]), 32'h00E00);
      check("blink2_gen", 32'(gen), 32'd2);

      // corner block
      for (int r = 0; r < ROWS; r++) model[r] = '0;
      model[0] = 20'h3;
      model[1] = 20'h3;
      load_grid();
      run_gen("block");
      check("block_r0", 32'(mem[0]), 32'h3);
      check("block_r1", 32'(mem[1]), 32'h3);
      check("block_r2", 32'(mem[2]), 32'h0);
      check("block_r14", 32'(mem[14]), 32'h0);

      // full grid
      for (int r = 0; r < ROWS; r++) model[r] = '1;
      load_grid();
      run_gen("full");
      check("full_r0", 32'(mem[0]), 32'h80001);
      check("full_r7", 32'(mem[7]), 32'h0);
      check("full_r14", 32'(mem[14]), 32'h80001);

      // random grids
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < ROWS; r++) model[r] = COLS'($urandom);
         load_grid();
         run_gen("rand");
      end

      // start held high across two generations
      for (int r = 0; r < ROWS; r++) model[r] = COLS'($urandom);
      load_grid();
      model_step(); push_expect(ROWS);
      model_step(); push_expect(ROWS);
      exp_gen = exp_gen + 16'd2;
      wr_cnt = 0; d1 = -1; d2 = -1; idle_between = 0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 150 && d2 < 0; k++) begin
         @(negedge clk);
         if (done) begin
            if (d1 < 0) d1 = k; else d2 = k;
         end
         if (d1 >= 0 && d2 < 0 && !busy) idle_between++;
      end
      start = 1'b0;
      check("held_done1", 32'(d1), 32'd48);
      check("held_done2", 32'(d2), 32'd97);
      check("held_idle_gap", 32'(idle_between), 32'd1);
      repeat (2) @(negedge clk);
      check("held_gen", 32'(gen), 32'(exp_gen));
      check("held_writes", 32'(wr_cnt), 32'd30);
      check("held_busy_after", 32'(busy), 32'd0);

      // reset during write of row 5
      for (int r = 0; r < ROWS; r++) begin
         model[r] = COLS'($urandom);
         old_grid[r] = model[r];
      end
      load_grid();
      model_step();
      push_expect(6);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      hit = 0;
      for (int k = 1; k <= 60 && hit == 0; k++) begin
         @(negedge clk);
         if (wr_en && wr_row == 4'd5) hit = 1;
      end
      check("abort_reached_row5", 32'(hit), 32'd1);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_gen", 32'(gen), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_writes", 32'(busy | wr_en), 32'd0);
      for (int r = 0; r < ROWS; r++) begin
         if (r < 5) check("abort_row_new", 32'(mem[r]), 32'(model[r]));
         else       check("abort_row_old", 32'(mem[r]), 32'(old_grid[r]));
      end
      check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
